// File: rtl/regfile_wb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared definitions for the register-file write-back arbiter.
//   - Default address/data/counter widths.
//   - wb_src_e  : round-robin pointer encoding (which source wins a conflict).
//   - wb_req_t  : a write request {rd, data} at the default widths.
//   - other_src : flips the round-robin pointer.
// Optional feature macro used by the files importing this package: WB_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_wb_pkg;

   localparam int WB_ADDR_WIDTH = 5;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_CNT_WIDTH  = 2;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [WB_ADDR_WIDTH-1:0] rd;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_req_t;

   function automatic wb_src_e other_src(input wb_src_e src);
      return (src == SRC_ALU) ? SRC_LSU : SRC_ALU;
   endfunction

endpackage : regfile_wb_pkg

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Per-register pending-writer counters used by decode to stall on RAW hazards.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid, issue_rd    decode issues an instruction writing issue_rd
//   issue_ready              low when the counter for issue_rd is saturated
//   wr_en, wr_rd             register-file write happening this cycle
//   query_ra, query_rb       decode source registers
//   busy_a, busy_b           source has a pending writer
//   fwd_a_valid, fwd_b_valid (WB_BYPASS_EN only) source can take the value
//                            being written this cycle instead of stalling
//
// Macro WB_BYPASS_EN: when defined, the last pending write to a register is
// forwarded in its RegWr cycle and busy is suppressed for that source.
// -----------------------------------------------------------------------------
module wb_scoreboard
   import regfile_wb_pkg::*;
#(
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int CNT_WIDTH  = WB_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_rd,
   input  logic [ADDR_WIDTH-1:0] query_ra,
   input  logic [ADDR_WIDTH-1:0] query_rb,
`ifdef WB_BYPASS_EN
   output logic                  fwd_a_valid,
   output logic                  fwd_b_valid,
`endif
   output logic                  busy_a,
   output logic                  busy_b
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];

   logic issue_fire;
   logic retire;

   // A saturated counter may still accept an issue when the same register
   // retires this cycle: the increment and decrement cancel.
   assign issue_ready = (cnt_q[issue_rd] != CNT_MAX) || (wr_en && (wr_rd == issue_rd));

   // x0 is never tracked, so it can never look busy.
   assign issue_fire = issue_valid && issue_ready && (issue_rd != '0);

   // Underflow guard: a retire against an empty counter is ignored.
   assign retire = wr_en && (cnt_q[wr_rd] != '0);

   always_comb begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves it unassigned would infer a latch.
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (issue_fire && (issue_rd == ADDR_WIDTH'(i)) &&
             !(retire && (wr_rd == ADDR_WIDTH'(i)))) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (retire && (wr_rd == ADDR_WIDTH'(i)) &&
                      !(issue_fire && (issue_rd == ADDR_WIDTH'(i)))) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the counter array is a bank of flops, not a RAM, and it must
         // clear on reset; stale counts would stall decode indefinitely.
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         cnt_q <= cnt_d;
      end
   end

`ifdef WB_BYPASS_EN
   logic wr_last;

   // The write in flight is the only remaining writer of wr_rd, so its data
   // is the final value decode needs.
   assign wr_last     = wr_en && (wr_rd != '0) && (cnt_q[wr_rd] == CNT_ONE);
   assign fwd_a_valid = wr_last && (wr_rd == query_ra);
   assign fwd_b_valid = wr_last && (wr_rd == query_rb);
   assign busy_a      = (cnt_q[query_ra] != '0) && !fwd_a_valid;
   assign busy_b      = (cnt_q[query_rb] != '0) && !fwd_b_valid;
`else
   // Without forwarding the source stays busy through its RegWr cycle.
   assign busy_a = (cnt_q[query_ra] != '0);
   assign busy_b = (cnt_q[query_rb] != '0);
`endif

`ifndef SYNTHESIS
   a_no_underflow : assert property (@(posedge clk) disable iff (rst)
      wr_en |-> (cnt_q[wr_rd] != '0));
`endif

endmodule : wb_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates ALU and LSU results onto the single register-file write port and
// tracks in-flight destinations so decode can stall on RAW hazards.
//
// Ports:
//   Wrclk, rst                        clock, asynchronous active-high reset
//   issue_valid/issue_rd/issue_ready  decode issue handshake
//   alu_valid/alu_rd/alu_data/alu_ready  ALU result handshake
//   lsu_valid/lsu_rd/lsu_data/lsu_ready  load result handshake
//   query_ra/query_rb, busy_a/busy_b  hazard lookup for decode sources
//   Rw/busW/RegWr                     register-file write port
//   fwd_a_valid/fwd_b_valid/fwd_data  (WB_BYPASS_EN only) write-back forwarding
//
// Macro WB_BYPASS_EN: adds forwarding of the final pending write so decode
// does not stall through the RegWr cycle.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int CNT_WIDTH  = WB_CNT_WIDTH
) (
   input  logic                  Wrclk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] query_ra,
   input  logic [ADDR_WIDTH-1:0] query_rb,
   output logic                  busy_a,
   output logic                  busy_b,
`ifdef WB_BYPASS_EN
   output logic                  fwd_a_valid,
   output logic                  fwd_b_valid,
   output logic [DATA_WIDTH-1:0] fwd_data,
`endif
   output logic [ADDR_WIDTH-1:0] Rw,
   output logic [DATA_WIDTH-1:0] busW,
   output logic                  RegWr
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   // Round-robin pointer: which source wins the next conflict.
   wb_src_e ptr_q, ptr_d;

   logic grant_alu;
   logic grant_lsu;
   req_t alu_req;
   req_t lsu_req;
   req_t sel_req;

   logic [ADDR_WIDTH-1:0] rw_q, rw_d;
   logic [DATA_WIDTH-1:0] busw_q, busw_d;
   logic                  regwr_q, regwr_d;

   assign alu_req = '{rd: alu_rd, data: alu_data};
   assign lsu_req = '{rd: lsu_rd, data: lsu_data};

   // Arbiter: a lone requester always wins; the pointer moves only when both
   // sources compete, so an idle source never loses its turn.
   always_comb begin
      grant_alu = 1'b0;
      grant_lsu = 1'b0;
      ptr_d     = ptr_q;
      if (alu_valid && lsu_valid) begin
         if (ptr_q == SRC_LSU) begin
            grant_lsu = 1'b1;
         end else begin
            grant_alu = 1'b1;
         end
         ptr_d = other_src(ptr_q);
      end else begin
         grant_alu = alu_valid;
         grant_lsu = lsu_valid;
      end
   end

   assign alu_ready = grant_alu;
   assign lsu_ready = grant_lsu;
   assign sel_req   = grant_lsu ? lsu_req : alu_req;

   // Write stage: one register between accept and the RF write port. A write
   // to x0 completes its handshake but never raises RegWr.
   always_comb begin
      rw_d    = rw_q;
      busw_d  = busw_q;
      regwr_d = 1'b0;
      if (grant_alu || grant_lsu) begin
         rw_d    = sel_req.rd;
         busw_d  = sel_req.data;
         regwr_d = (sel_req.rd != '0);
      end
   end

   always_ff @(posedge Wrclk or posedge rst) begin
      if (rst) begin
         ptr_q   <= SRC_LSU;
         rw_q    <= '0;
         busw_q  <= '0;
         regwr_q <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         rw_q    <= rw_d;
         busw_q  <= busw_d;
         regwr_q <= regwr_d;
      end
   end

   assign Rw    = rw_q;
   assign busW  = busw_q;
   assign RegWr = regwr_q;

`ifdef WB_BYPASS_EN
   assign fwd_data = busw_q;
`endif

   wb_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_scoreboard (
      .clk         (Wrclk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .wr_en       (regwr_q),
      .wr_rd       (rw_q),
      .query_ra    (query_ra),
      .query_rb    (query_rb),
`ifdef WB_BYPASS_EN
      .fwd_a_valid (fwd_a_valid),
      .fwd_b_valid (fwd_b_valid),
`endif
      .busy_a      (busy_a),
      .busy_b      (busy_b)
   );

endmodule : regfile_wb_arbiter
